alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
- Two-stage execute/writeback pipeline around the combinational ALU (BITS-wide a/b/op in, z/o_flags out).
- Accepts decoded instructions, reads operands from an internal register file with forwarding, and drives the ALU.
- Registers the ALU result and flags, retires them to the register file through a writeback handshake, and keeps last/sticky flag registers.

Parameters:
BITS, 8, datapath width; matches the ALU BITS.
REGS, 4, register-file entries; r0 reads as zero.
RADDR, 2, register index width; equals log2(REGS).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  instruction offered
in_ready  out  1  stage accepts the instruction this cycle
in_op  in  BITS  ALU opcode: [4:0] operation, [7:5] modifier
in_rd  in  RADDR  destination register
in_ra  in  RADDR  source register for a
in_rb  in  RADDR  source register for b
in_imm  in  BITS  immediate value
in_use_imm  in  1  1: b = in_imm; 0: b = reg[in_rb]
alu_a  out  BITS  to ALU a
alu_b  out  BITS  to ALU b
alu_op  out  BITS  to ALU op
alu_z  in  BITS  from ALU z
alu_flags  in  8  from ALU o_flags
wb_valid  out  1  retiring result present
wb_ready  in  1  consumer accepts the retire
wb_rd  out  RADDR  retiring destination
wb_data  out  BITS  retiring result
wb_we  out  1  retiring result writes the register file
flags_last  out  8  flags of the most recently retired instruction
flags_sticky  out  8  accumulated bits 0, 1, 4, 5 (overflow, underflow, div-by-0, unknown op)
flags_clr  in  1  clears flags_sticky

Behaviour:
- Reset: every valid bit, wb_*, flags_last, flags_sticky and all register-file entries go to 0; in_ready reads 1 in the first cycle after reset. Reset mid-operation discards in-flight instructions with no register-file writes.
- EX register (ex_valid, op, rd, a, b, we) drives alu_a/alu_b/alu_op directly. When ex_valid=0, the ALU outputs are ignored.
- Advance rules:
  - wb_fire = wb_valid & wb_ready
  - ex_adv = ex_valid & (!wb_valid | wb_ready)
  - in_ready = !ex_valid | ex_adv
  - accept = in_valid & in_ready
- Latency: accept at edge N; ALU evaluates in cycle N+1; wb_valid=1 from N+2; register file updated at the first edge with wb_fire.
- Operand read at accept, priority highest first:
  1. Index 0 reads 0.
  2. Forward alu_z if ex_valid & ex_we & ex_rd == index.
  3. Forward wb_data if wb_valid & wb_we & wb_rd == index.
  4. Otherwise reg[index].
  - b comes from in_imm when in_use_imm=1.
- ex_we = 0 when any of the following holds:
  - rd == 0
  - op[4:0] == 4 and op[7:5] is 000, 011 or 111 (CMP with no output)
  - op[4:0] is not one of the implemented opcodes 0–11, 13, 14
  - Otherwise ex_we = 1.
- On ex_adv, WB captures alu_z, alu_flags, rd and we. WB outputs hold stable while wb_valid & !wb_ready.
- If ex_adv and wb_fire happen in the same cycle, the WB register reloads with no bubble.
- On wb_fire:
  - reg[wb_rd] <= wb_data if wb_we.
  - flags_last <= captured flags.
  - flags_sticky <= (flags_sticky & ~{8{flags_clr}}) | (captured flags & 8'b00110011).
- flags_clr without wb_fire zeroes flags_sticky. flags_clr together with wb_fire: the new bits are set (set wins).
- A full pipeline with wb_ready=0 gives in_ready=0. No instruction is lost or duplicated.
- Throughput is one instruction per cycle while wb_ready=1.

Test Plan:
- Reset, then wb_ready=1. Issue ADD r1 = r0 + imm 5 (op=0), then ADD r2 = r1 + imm 3 back-to-back -> wb_data 5 at cycle 2 and 8 at cycle 3 (EX forward). reg r2 = 8.
- ADD r1 = imm 200 + imm 100 via two writes (r1 = 200, then r1 = r1 + imm 100) -> wb_data 44, flags_last = 8'h01, flags_sticky = 8'h01. Then flags_clr -> sticky 0; flags_last unchanged.
- DIV r3 = r1 / imm 0 (op=3) -> wb_data 0, flags_last = 8'h10, sticky bit4 set. CMP op = 8'h04 (modifier 000) -> wb_we = 0, r-file unchanged.
- Hold wb_ready=0 with 3 instructions offered -> wb_valid=1 and in_ready=0 after two accepts, wb_data stable. Release -> the three retire in order on consecutive cycles.
- Opcode 15 to r2 -> flags_last = 8'h20, wb_we = 0, sticky bit5 set. Write to r0 -> r0 still reads 0.
- Assert rst while two instructions are in flight -> wb_valid = 0 next cycle, all registers and flags 0, no write occurs.

Source files
------------

// File: rtl/alu_exec_stage.sv
// Two-stage execute/writeback pipeline wrapped around an external combinational ALU.
// Operands come from a small register file with EX/WB forwarding; retired flags are kept as last/sticky.
module alu_exec_stage #(
  parameter int BITS  = 8,
  parameter int REGS  = 4,
  parameter int RADDR = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BITS-1:0]  in_op,
  input  logic [RADDR-1:0] in_rd,
  input  logic [RADDR-1:0] in_ra,
  input  logic [RADDR-1:0] in_rb,
  input  logic [BITS-1:0]  in_imm,
  input  logic             in_use_imm,
  output logic [BITS-1:0]  alu_a,
  output logic [BITS-1:0]  alu_b,
  output logic [BITS-1:0]  alu_op,
  input  logic [BITS-1:0]  alu_z,
  input  logic [7:0]       alu_flags,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [RADDR-1:0] wb_rd,
  output logic [BITS-1:0]  wb_data,
  output logic             wb_we,
  output logic [7:0]       flags_last,
  output logic [7:0]       flags_sticky,
  input  logic             flags_clr
);

  // overflow, underflow, div-by-0 and unknown-op accumulate; the rest are per-instruction only
  localparam logic [7:0] STICKY_MASK = 8'b0011_0011;

  function automatic logic dest_writes(input logic [7:0] op, input logic [RADDR-1:0] rd);
    logic impl;
    case (op[4:0])
      5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 5'd6, 5'd7, 5'd8,
      5'd9, 5'd10, 5'd11, 5'd13, 5'd14: impl = 1'b1;
      5'd4: begin
        case (op[7:5])
          3'b000, 3'b011, 3'b111: impl = 1'b0;
          default:                impl = 1'b1;
        endcase
      end
      default: impl = 1'b0;
    endcase
    return impl & (rd != {RADDR{1'b0}});
  endfunction

  function automatic logic [BITS-1:0] read_operand(
    input logic [RADDR-1:0] idx,
    input logic [BITS-1:0]  rf_val,
    input logic             ex_en,
    input logic [RADDR-1:0] ex_rd,
    input logic [BITS-1:0]  ex_val,
    input logic             wb_en,
    input logic [RADDR-1:0] wb_rd_i,
    input logic [BITS-1:0]  wb_val
  );
    logic [BITS-1:0] val;
    if (idx == {RADDR{1'b0}}) begin
      val = {BITS{1'b0}};
    end else if (ex_en && (ex_rd == idx)) begin
      val = ex_val;
    end else if (wb_en && (wb_rd_i == idx)) begin
      val = wb_val;
    end else begin
      val = rf_val;
    end
    return val;
  endfunction

  logic [BITS-1:0]  rf_r [REGS];

  logic             ex_valid_r;
  logic             ex_we_r;
  logic [BITS-1:0]  ex_op_r;
  logic [RADDR-1:0] ex_rd_r;
  logic [BITS-1:0]  ex_a_r;
  logic [BITS-1:0]  ex_b_r;

  logic             wb_valid_r;
  logic             wb_we_r;
  logic [RADDR-1:0] wb_rd_r;
  logic [BITS-1:0]  wb_data_r;
  logic [7:0]       wb_flags_r;

  logic [7:0]       flags_last_r;
  logic [7:0]       flags_sticky_r;

  logic             wb_fire_s;
  logic             ex_adv_s;
  logic             in_ready_s;
  logic             accept_s;
  logic [BITS-1:0]  opnd_a_s;
  logic [BITS-1:0]  opnd_b_s;
  logic             in_we_s;

  // Pipeline advance handshake.
  always_comb begin
    wb_fire_s  = wb_valid_r & wb_ready;
    ex_adv_s   = ex_valid_r & (~wb_valid_r | wb_ready);
    in_ready_s = ~ex_valid_r | ex_adv_s;
    accept_s   = in_valid & in_ready_s;
  end

  // Operand selection at accept; the in-flight EX result beats the WB result.
  always_comb begin
    opnd_a_s = read_operand(in_ra, rf_r[in_ra], ex_valid_r & ex_we_r, ex_rd_r, alu_z,
                            wb_valid_r & wb_we_r, wb_rd_r, wb_data_r);
    if (in_use_imm) begin
      opnd_b_s = in_imm;
    end else begin
      opnd_b_s = read_operand(in_rb, rf_r[in_rb], ex_valid_r & ex_we_r, ex_rd_r, alu_z,
                              wb_valid_r & wb_we_r, wb_rd_r, wb_data_r);
    end
    in_we_s = dest_writes(in_op[7:0], in_rd);
  end

  // EX register: loads on accept, empties when its instruction moves on with nothing behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_r <= 1'b0;
      ex_we_r    <= 1'b0;
      ex_op_r    <= {BITS{1'b0}};
      ex_rd_r    <= {RADDR{1'b0}};
      ex_a_r     <= {BITS{1'b0}};
      ex_b_r     <= {BITS{1'b0}};
    end else if (accept_s) begin
      ex_valid_r <= 1'b1;
      ex_we_r    <= in_we_s;
      ex_op_r    <= in_op;
      ex_rd_r    <= in_rd;
      ex_a_r     <= opnd_a_s;
      ex_b_r     <= opnd_b_s;
    end else if (ex_adv_s) begin
      ex_valid_r <= 1'b0;
    end
  end

  // WB register: captures the ALU result on advance, holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_r <= 1'b0;
      wb_we_r    <= 1'b0;
      wb_rd_r    <= {RADDR{1'b0}};
      wb_data_r  <= {BITS{1'b0}};
      wb_flags_r <= 8'h00;
    end else if (ex_adv_s) begin
      wb_valid_r <= 1'b1;
      wb_we_r    <= ex_we_r;
      wb_rd_r    <= ex_rd_r;
      wb_data_r  <= alu_z;
      wb_flags_r <= alu_flags;
    end else if (wb_fire_s) begin
      wb_valid_r <= 1'b0;
    end
  end

  // Register file write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REGS; i++) begin
        rf_r[i] <= {BITS{1'b0}};
      end
    end else if (wb_fire_s && wb_we_r) begin
      rf_r[wb_rd_r] <= wb_data_r;
    end
  end

  // Flag tracking: a retire that coincides with a clear still sets its sticky bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_last_r   <= 8'h00;
      flags_sticky_r <= 8'h00;
    end else if (wb_fire_s) begin
      flags_last_r   <= wb_flags_r;
      flags_sticky_r <= (flags_sticky_r & ~{8{flags_clr}}) | (wb_flags_r & STICKY_MASK);
    end else if (flags_clr) begin
      flags_sticky_r <= 8'h00;
    end
  end

  assign in_ready     = in_ready_s;
  assign alu_a        = ex_a_r;
  assign alu_b        = ex_b_r;
  assign alu_op       = ex_op_r;
  assign wb_valid     = wb_valid_r;
  assign wb_rd        = wb_rd_r;
  assign wb_data      = wb_data_r;
  assign wb_we        = wb_we_r;
  assign flags_last   = flags_last_r;
  assign flags_sticky = flags_sticky_r;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: a behavioural ALU drives the DUT, a scoreboard checks every retire.
module tb_alu_exec_stage;
  localparam int BITS = 8;
  localparam int REGS = 4;
  localparam int RADDR = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_op = 8'h00;
  logic [1:0] in_rd = 2'd0, in_ra = 2'd0, in_rb = 2'd0;
  logic [7:0] in_imm = 8'h00;
  logic       in_use_imm = 1'b0;
  logic [7:0] alu_a, alu_b, alu_op, alu_z, alu_flags;
  logic       wb_valid;
  logic       wb_ready = 1'b1;
  logic [1:0] wb_rd;
  logic [7:0] wb_data;
  logic       wb_we;
  logic [7:0] flags_last, flags_sticky;
  logic       flags_clr = 1'b0;

  always #5 clk = ~clk;

  alu_exec_stage #(.BITS(BITS), .REGS(REGS), .RADDR(RADDR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_ra(in_ra), .in_rb(in_rb), .in_imm(in_imm), .in_use_imm(in_use_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_z(alu_z), .alu_flags(alu_flags),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data), .wb_we(wb_we),
    .flags_last(flags_last), .flags_sticky(flags_sticky), .flags_clr(flags_clr)
  );

  // Behavioural ALU: {z, flags}
  function automatic logic [15:0] alu_f(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0]  s;
    logic [15:0] p;
    logic [7:0]  z;
    logic [7:0]  f;
    s = 9'h000; p = 16'h0000; z = 8'h00; f = 8'h00;
    case (op[4:0])
      5'd0: begin s = {1'b0, a} + {1'b0, b}; z = s[7:0]; f[0] = s[8]; end
      5'd1: begin z = a - b; f[1] = (a < b); end
      5'd2: begin p = {8'h00, a} * {8'h00, b}; z = p[7:0]; f[0] = |p[15:8]; end
      5'd3: begin if (b == 8'h00) f[4] = 1'b1; else z = a / b; end
      5'd4: begin
        f[2] = (a == b); f[3] = (a < b);
        case (op[7:5])
          3'd1:    z = {7'd0, a == b};
          3'd2:    z = {7'd0, a < b};
          default: z = 8'h00;
        endcase
      end
      5'd5:  z = a & b;
      5'd6:  z = a | b;
      5'd7:  z = a ^ b;
      5'd8:  z = ~a;
      5'd9:  z = a << b[2:0];
      5'd10: z = a >> b[2:0];
      5'd11: z = b;
      5'd13: z = a + 8'd1;
      5'd14: z = a - 8'd1;
      default: f[5] = 1'b1;
    endcase
    return {z, f};
  endfunction

  assign {alu_z, alu_flags} = alu_f(alu_op, alu_a, alu_b);

  typedef struct {
    logic [7:0] op; logic [1:0] rd; logic [1:0] ra; logic [1:0] rb;
    logic [7:0] imm; logic ui; logic [7:0] exp_data; logic exp_we; logic [7:0] exp_flags;
  } vec_t;
  typedef struct { logic [1:0] rd; logic [7:0] data; logic we; logic [7:0] flags; } exp_t;

  exp_t sb_q[$];
  int   fire_cyc_q[$];
  int   n_checks = 0;
  int   n_miss = 0;
  int   cyc = 0;
  logic flags_pend = 1'b0;
  logic [7:0] pend_flags = 8'h00;
  vec_t vecs[14];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] op, input logic [1:0] rd, input logic [1:0] ra,
                              input logic [1:0] rb, input logic [7:0] imm, input logic ui,
                              input logic [7:0] d, input logic we, input logic [7:0] f);
    vec_t v;
    v.op = op; v.rd = rd; v.ra = ra; v.rb = rb; v.imm = imm; v.ui = ui;
    v.exp_data = d; v.exp_we = we; v.exp_flags = f;
    return v;
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb_q.delete();
      flags_pend = 1'b0;
    end else begin
      if (flags_pend) begin
        check("flags_last", 32'(flags_last), 32'(pend_flags));
        flags_pend = 1'b0;
      end
      if (wb_valid && wb_ready) begin
        fire_cyc_q.push_back(cyc);
        if (sb_q.size() == 0) begin
          check("unexpected_retire", 32'(1), 32'(0));
        end else begin
          e = sb_q.pop_front();
          check("wb_rd", 32'(wb_rd), 32'(e.rd));
          check("wb_data", 32'(wb_data), 32'(e.data));
          check("wb_we", 32'(wb_we), 32'(e.we));
          pend_flags = e.flags;
          flags_pend = 1'b1;
        end
      end
    end
  end

  task automatic drive(input vec_t v);
    in_valid = 1'b1; in_op = v.op; in_rd = v.rd; in_ra = v.ra; in_rb = v.rb;
    in_imm = v.imm; in_use_imm = v.ui;
  endtask

  task automatic issue(input vec_t v);
    bit done;
    done = 1'b0;
    drive(v);
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back('{v.rd, v.exp_data, v.exp_we, v.exp_flags});
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) check("issue_timeout", 32'(0), 32'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(posedge clk); #1;
      if (sb_q.size() == 0 && !wb_valid) done = 1'b1;
    end
    if (!done) check("drain_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    bit seen;
    vecs[0]  = mk(8'h00, 2'd1, 2'd0, 2'd0, 8'd5,   1'b1, 8'd5,  1'b1, 8'h00);
    vecs[1]  = mk(8'h00, 2'd2, 2'd1, 2'd0, 8'd3,   1'b1, 8'd8,  1'b1, 8'h00);
    vecs[2]  = mk(8'h00, 2'd1, 2'd0, 2'd0, 8'd200, 1'b1, 8'd200, 1'b1, 8'h00);
    vecs[3]  = mk(8'h00, 2'd1, 2'd1, 2'd0, 8'd100, 1'b1, 8'd44, 1'b1, 8'h01);
    vecs[4]  = mk(8'h03, 2'd3, 2'd1, 2'd0, 8'd0,   1'b1, 8'd0,  1'b1, 8'h10);
    vecs[5]  = mk(8'h04, 2'd2, 2'd1, 2'd2, 8'd0,   1'b0, 8'd0,  1'b0, 8'h00);
    vecs[6]  = mk(8'h0F, 2'd2, 2'd1, 2'd0, 8'd7,   1'b1, 8'd0,  1'b0, 8'h20);
    vecs[7]  = mk(8'h00, 2'd0, 2'd1, 2'd0, 8'd1,   1'b1, 8'd45, 1'b0, 8'h00);
    vecs[8]  = mk(8'h00, 2'd3, 2'd0, 2'd2, 8'd0,   1'b0, 8'd8,  1'b1, 8'h00);
    vecs[9]  = mk(8'h01, 2'd1, 2'd3, 2'd0, 8'd9,   1'b1, 8'hFF, 1'b1, 8'h02);
    vecs[10] = mk(8'h02, 2'd2, 2'd1, 2'd1, 8'd0,   1'b0, 8'h01, 1'b1, 8'h01);
    vecs[11] = mk(8'h07, 2'd3, 2'd2, 2'd0, 8'hF0,  1'b1, 8'hF1, 1'b1, 8'h00);
    vecs[12] = mk(8'h00, 2'd1, 2'd3, 2'd2, 8'd0,   1'b0, 8'hF2, 1'b1, 8'h00);
    vecs[13] = mk(8'h44, 2'd2, 2'd3, 2'd1, 8'd0,   1'b0, 8'h01, 1'b1, 8'h08);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_wb_valid", 32'(wb_valid), 32'(0));
    check("rst_wb_data", 32'(wb_data), 32'(0));
    check("rst_flags_last", 32'(flags_last), 32'(0));
    check("rst_flags_sticky", 32'(flags_sticky), 32'(0));

    for (int i = 0; i < 14; i++) issue(vecs[i]);
    drain();
    check("sticky_accum", 32'(flags_sticky), 32'(8'h33));
    check("last_after_table", 32'(flags_last), 32'(8'h08));

    // clear without a retire
    flags_clr = 1'b1;
    @(posedge clk); #1 flags_clr = 1'b0;
    check("sticky_cleared", 32'(flags_sticky), 32'(0));
    check("last_kept", 32'(flags_last), 32'(8'h08));

    // clear held across a retire: the retiring bits survive
    flags_clr = 1'b1;
    issue(mk(8'h03, 2'd1, 2'd0, 2'd0, 8'd0, 1'b1, 8'd0, 1'b1, 8'h10));
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (wb_valid) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!seen) check("clr_fire_timeout", 32'(0), 32'(1));
    @(posedge clk); #1 flags_clr = 1'b0;
    check("clr_fire_sticky", 32'(flags_sticky), 32'(8'h10));
    check("clr_fire_last", 32'(flags_last), 32'(8'h10));
    drain();

    // back-pressure
    wb_ready = 1'b0;
    issue(mk(8'h00, 2'd1, 2'd0, 2'd0, 8'd10, 1'b1, 8'd10, 1'b1, 8'h00));
    issue(mk(8'h00, 2'd2, 2'd1, 2'd0, 8'd1,  1'b1, 8'd11, 1'b1, 8'h00));
    drive(mk(8'h00, 2'd3, 2'd2, 2'd1, 8'd0,  1'b0, 8'd21, 1'b1, 8'h00));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'(0));
      check("stall_wb_valid", 32'(wb_valid), 32'(1));
      check("stall_wb_data", 32'(wb_data), 32'(10));
      @(posedge clk); #1;
    end
    fire_cyc_q.delete();
    wb_ready = 1'b1;
    issue(mk(8'h00, 2'd3, 2'd2, 2'd1, 8'd0, 1'b0, 8'd21, 1'b1, 8'h00));
    drain();
    check("release_retires", 32'(fire_cyc_q.size()), 32'(3));
    if (fire_cyc_q.size() == 3) begin
      check("release_gap1", 32'(fire_cyc_q[1] - fire_cyc_q[0]), 32'(1));
      check("release_gap2", 32'(fire_cyc_q[2] - fire_cyc_q[1]), 32'(1));
    end

    // reset with two instructions in flight
    issue(mk(8'h00, 2'd1, 2'd0, 2'd0, 8'd77, 1'b1, 8'd77, 1'b1, 8'h00));
    issue(mk(8'h00, 2'd2, 2'd0, 2'd0, 8'd66, 1'b1, 8'd66, 1'b1, 8'h00));
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_wb_valid", 32'(wb_valid), 32'(0));
    check("midrst_in_ready", 32'(in_ready), 32'(1));
    check("midrst_sticky", 32'(flags_sticky), 32'(0));
    check("midrst_last", 32'(flags_last), 32'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    issue(mk(8'h00, 2'd3, 2'd1, 2'd2, 8'd0, 1'b0, 8'd0, 1'b1, 8'h00));
    issue(mk(8'h06, 2'd1, 2'd3, 2'd0, 8'h5A, 1'b1, 8'h5A, 1'b1, 8'h00));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
